register_file_checker: RTL and testbench

- Parametrised, clocked checker that runs beside the register file and watches its write port and every read port.
- Keeps a shadow copy of the architectural registers and checks each read against it.
  - Reads of x0 must return zero.
  - Reads of a register already written must return the last value written.
- Mismatches are reported through a sticky error flag, a saturating error counter and a capture of the first failure. Fatal-stop behaviour is selected at compile time.
- Instantiated only in the verification environment. Never synthesised into the core.

---
 rtl/register_file_checker.sv | 149 ++++++++++++++
 tb/tb_register_file_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_checker.sv
// register_file_checker: verification-only monitor that sits beside a register
// file. It shadows every architectural write and compares each read port
// against the shadow. Mismatches set a sticky flag, bump a saturating counter
// and capture the first failing port/register.
// Compile-time option: define REG_FILE_CHECK_FATAL_EN to stop simulation with
// $fatal on the edge that first raises err.
module register_file_checker #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int CNT_WIDTH    = 16,
  localparam int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           chk_en,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_reg,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_reg,
  input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic                           err,
  output logic [CNT_WIDTH-1:0]           err_count,
  output logic [1:0]                     first_err_port,
  output logic [ADDR_W-1:0]              first_err_reg,
  output logic [CNT_WIDTH-1:0]           x0_wr_count
);

  // Wide enough to hold the counter plus up to four new mismatches.
  localparam int SUM_W = CNT_WIDTH + 3;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  logic [DATA_WIDTH-1:0]   shadow_mem [NUM_REGS];
  logic [NUM_REGS-1:0]     valid_reg;
  logic [NUM_RD_PORTS-1:0] mismatch;
  logic [2:0]              mism_count;
  logic [1:0]              first_port_next;
  logic [ADDR_W-1:0]       first_reg_next;
  logic [SUM_W-1:0]        err_sum;
  logic [CNT_WIDTH-1:0]    err_count_next;
  logic                    x0_write;

  // Per-port comparison. The shadow is looked up combinationally so a read in
  // the same cycle as a write to the same register sees the pre-edge value.
  generate
    for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
      logic [ADDR_W-1:0]     port_reg;
      logic [DATA_WIDTH-1:0] port_data;
      logic                  port_bad;

      assign port_reg  = rd_reg[gi*ADDR_W +: ADDR_W];
      assign port_data = rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
      // x0 must read zero; other registers are checked only once written.
      assign port_bad  = (port_reg == '0) ? (port_data != '0)
                                          : (valid_reg[port_reg] &&
                                             (port_data != shadow_mem[port_reg]));
      assign mismatch[gi] = chk_en && !rst && port_bad;
    end
  endgenerate

  // Count mismatching ports and pick the lowest-index one for capture.
  always_comb begin
    mism_count      = '0;
    first_port_next = '0;
    first_reg_next  = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      mism_count = mism_count + 3'(mismatch[p]);
    end
    for (int p = NUM_RD_PORTS - 1; p >= 0; p--) begin
      if (mismatch[p]) begin
        first_port_next = 2'(p);
        first_reg_next  = rd_reg[p*ADDR_W +: ADDR_W];
      end
    end
  end

  // Saturating accumulation of this cycle's mismatches.
  always_comb begin
    err_sum        = SUM_W'(err_count) + SUM_W'(mism_count);
    err_count_next = (err_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}}
                                         : err_sum[CNT_WIDTH-1:0];
  end

  assign x0_write = wr_en && (wr_reg == '0);

  // Shadow values carry no reset; the valid bits decide whether they matter.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && (wr_reg != '0)) begin
      shadow_mem[wr_reg] <= wr_data;
    end
  end

  // Error bookkeeping, valid bits and x0 write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err            <= 1'b0;
      err_count      <= '0;
      first_err_port <= '0;
      first_err_reg  <= '0;
      x0_wr_count    <= '0;
      valid_reg      <= '0;
    end else begin
      if (|mismatch) begin
        err       <= 1'b1;
        err_count <= err_count_next;
        if (!err) begin
          first_err_port <= first_port_next;
          first_err_reg  <= first_reg_next;
        end
      end
      if (x0_write) begin
        if (x0_wr_count != {CNT_WIDTH{1'b1}}) begin
          x0_wr_count <= x0_wr_count + 1'b1;
        end
      end else if (wr_en) begin
        valid_reg[wr_reg] <= 1'b1;
      end
    end
  end

`ifdef REG_FILE_CHECK_FATAL_EN
  logic [DATA_WIDTH-1:0] first_exp;
  logic [DATA_WIDTH-1:0] first_act;

  // Expected and observed data of the lowest-index mismatching port.
  always_comb begin
    first_exp = '0;
    first_act = '0;
    for (int p = NUM_RD_PORTS - 1; p >= 0; p--) begin
      if (mismatch[p]) begin
        first_act = rd_data[p*DATA_WIDTH +: DATA_WIDTH];
        first_exp = (rd_reg[p*ADDR_W +: ADDR_W] == '0) ? '0
                    : shadow_mem[rd_reg[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Stop the run on the edge that first raises err.
  always_ff @(posedge clk) begin
    if (!rst && !err && (|mismatch)) begin
      $fatal(1, "register_file_checker: port %0d reg x%0d expected 0x%h actual 0x%h",
             first_port_next, first_reg_next, first_exp, first_act);
    end
  end
`else
  // Errors are only recorded; the environment inspects err/err_count/first_err_*.
`endif

endmodule

// File: tb/tb_register_file_checker.sv
// tb_register_file_checker: directed scenarios followed by randomized traffic,
// every cycle checked against a behavioural model of the shadow register file.
module tb_register_file_checker;

  localparam int DW   = 32;
  localparam int NR   = 16;
  localparam int NP   = 2;
  localparam int CW   = 4;
  localparam int AW   = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            chk_en;
  logic            wr_en;
  logic [AW-1:0]   wr_reg;
  logic [DW-1:0]   wr_data;
  logic [NP*AW-1:0] rd_reg;
  logic [NP*DW-1:0] rd_data;
  logic            err;
  logic [CW-1:0]   err_count;
  logic [1:0]      first_err_port;
  logic [AW-1:0]   first_err_reg;
  logic [CW-1:0]   x0_wr_count;

  always #5 clk = ~clk;

  register_file_checker #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .wr_en(wr_en), .wr_reg(wr_reg),
    .wr_data(wr_data), .rd_reg(rd_reg), .rd_data(rd_data), .err(err),
    .err_count(err_count), .first_err_port(first_err_port),
    .first_err_reg(first_err_reg), .x0_wr_count(x0_wr_count)
  );

  // Reference model: register contents, written flags, error summary.
  logic [DW-1:0] m_val [NR];
  bit            m_vld [NR];
  bit            m_err;
  int            m_cnt, m_x0, m_fport, m_freg;
  int            checks = 0;
  int            passes = 0;
  int            cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_err = 0; m_cnt = 0; m_x0 = 0; m_fport = 0; m_freg = 0;
    for (int i = 0; i < NR; i++) m_vld[i] = 0;
  endtask

  // One clock cycle: drive, predict from the rules, clock, compare.
  task automatic cycle(input bit r, input bit c, input bit we, input int wreg_i,
                       input logic [DW-1:0] wd, input int r0, input logic [DW-1:0] d0,
                       input int r1, input logic [DW-1:0] d1);
    int            rr [NP];
    logic [DW-1:0] dd [NP];
    int            k, fp, fr;
    bit            bad;
    rst = r; chk_en = c; wr_en = we; wr_reg = AW'(wreg_i); wr_data = wd;
    rd_reg = {AW'(r1), AW'(r0)};
    rd_data = {d1, d0};
    rr[0] = r0; rr[1] = r1; dd[0] = d0; dd[1] = d1;
    k = 0; fp = -1; fr = 0;
    if (!r && c) begin
      for (int p = 0; p < NP; p++) begin
        if (rr[p] == 0) bad = (dd[p] != 0);
        else            bad = m_vld[rr[p]] && (dd[p] != m_val[rr[p]]);
        if (bad) begin
          k++;
          if (fp < 0) begin fp = p; fr = rr[p]; end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      if (k > 0) begin
        if (!m_err) begin m_fport = fp; m_freg = fr; end
        m_err = 1;
        m_cnt = (m_cnt + k > CMAX) ? CMAX : m_cnt + k;
      end
      if (we) begin
        if (wreg_i == 0) m_x0 = (m_x0 + 1 > CMAX) ? CMAX : m_x0 + 1;
        else begin m_val[wreg_i] = wd; m_vld[wreg_i] = 1; end
      end
    end
    $display("cyc %0d rst=%0b chk=%0b we=%0b wr=x%0d rd=x%0d/x%0d bad=%0d err=%0b cnt=%0d fp=%0d fr=%0d x0=%0d",
             cyc, r, c, we, wreg_i, r0, r1, k, err, err_count, first_err_port,
             first_err_reg, x0_wr_count);
    check("err", err, m_err);
    check("err_count", err_count, m_cnt);
    check("first_err_port", first_err_port, m_fport);
    check("first_err_reg", first_err_reg, m_freg);
    check("x0_wr_count", x0_wr_count, m_x0);
  endtask

  task automatic idle();
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1, 1, 1, 3, 32'h5555, 0, 1, 0, 1);
  endtask

  initial begin
    int r0, r1, wr;
    logic [DW-1:0] d0, d1;
    model_reset();

    // Reset state
    do_reset();
    do_reset();
    check("rst_err", err, 0);
    check("rst_cnt", err_count, 0);
    check("rst_x0", x0_wr_count, 0);

    // x0 reads
    repeat (10) idle();
    check("x0_clean_err", err, 0);
    check("x0_clean_cnt", err_count, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 32'h1);
    check("x0_err", err, 1);
    check("x0_cnt", err_count, 1);
    check("x0_port", first_err_port, 1);
    check("x0_reg", first_err_reg, 0);

    // Written register
    do_reset();
    cycle(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
    check("x5_ok", err, 0);
    cycle(0, 1, 0, 0, 0, 5, 32'hDEADBEEE, 0, 0);
    check("x5_cnt", err_count, 1);
    check("x5_reg", first_err_reg, 5);
    check("x5_port", first_err_port, 0);

    // Read-before-write
    do_reset();
    cycle(0, 1, 1, 7, 32'h11, 0, 0, 0, 0);
    cycle(0, 1, 1, 7, 32'h22, 7, 32'h11, 0, 0);
    check("rbw_old", err, 0);
    cycle(0, 1, 0, 0, 0, 7, 32'h22, 0, 0);
    check("rbw_new", err, 0);

    // Both ports mismatch, then saturation
    cycle(0, 1, 0, 0, 0, 7, 32'h33, 7, 32'h44);
    check("multi_cnt", err_count, 2);
    check("multi_port", first_err_port, 0);
    check("multi_reg", first_err_reg, 7);
    repeat (20) cycle(0, 1, 0, 0, 0, 0, 32'h1, 0, 32'h2);
    check("sat_cnt", err_count, 15);
    check("sat_hold_port", first_err_port, 0);

    // x0 writes
    do_reset();
    repeat (3) cycle(0, 1, 1, 0, 32'hFF, 0, 0, 0, 0);
    check("x0w_cnt", x0_wr_count, 3);
    idle();
    check("x0w_read", err, 0);
    repeat (20) cycle(0, 1, 1, 0, 32'hFF, 0, 0, 0, 0);
    check("x0w_sat", x0_wr_count, 15);

    // Reset mid-test clears history
    cycle(0, 1, 1, 5, 32'h1, 0, 0, 0, 0);
    do_reset();
    check("mid_rst_x0", x0_wr_count, 0);
    check("mid_rst_err", err, 0);
    cycle(0, 1, 0, 0, 0, 5, 32'h2, 0, 0);
    check("stale_x5", err, 0);

    // Unwritten register and disabled checking
    cycle(0, 1, 0, 0, 0, 9, 32'h12345678, 9, 32'hCAFE);
    check("unwritten", err, 0);
    cycle(0, 0, 0, 0, 0, 0, 32'h1, 0, 32'h1);
    check("chk_off", err, 0);
    check("chk_off_cnt", err_count, 0);

    // Randomized traffic
    do_reset();
    repeat (300) begin
      r0 = $urandom_range(NR - 1);
      r1 = $urandom_range(NR - 1);
      wr = $urandom_range(NR - 1);
      d0 = (r0 == 0) ? '0 : (m_vld[r0] ? m_val[r0] : DW'($urandom));
      d1 = (r1 == 0) ? '0 : (m_vld[r1] ? m_val[r1] : DW'($urandom));
      if ($urandom_range(9) < 2) d0 = DW'($urandom);
      if ($urandom_range(9) < 2) d1 = DW'($urandom);
      cycle(($urandom_range(49) == 0), ($urandom_range(9) != 0),
            ($urandom_range(1) == 1), wr, DW'($urandom), r0, d0, r1, d1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
